// File: rtl/reg_file_sb_if.sv
// Bundles the register-file read, write, issue and scoreboard signals.
// Latency: none, plain wires between the pipeline and the register file.
// Backpressure: none; busy1/busy2 are the stall indication for the consumer.
interface reg_file_sb_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]   adr1;
    logic [AW-1:0]   adr2;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy1;
    logic            busy2;
    logic            en;
    logic [AW-1:0]   w_adr;
    logic [XLEN-1:0] w_data;
    logic            iss_en;
    logic [AW-1:0]   iss_adr;
    logic [AW:0]     busy_cnt;

    // Pipeline side: issues destinations, writes back results, reads operands
    modport master (
        output adr1, adr2, en, w_adr, w_data, iss_en, iss_adr,
        input  rs1, rs2, busy1, busy2, busy_cnt
    );

    // Register-file side
    modport slave (
        input  adr1, adr2, en, w_adr, w_data, iss_en, iss_adr,
        output rs1, rs2, busy1, busy2, busy_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with a per-register busy scoreboard.
// Latency: reads are combinational (optional same-cycle write forwarding); writes, busy bits and busy_cnt update on the clock edge.
// Backpressure: none; writes and issues are always accepted, busy1/busy2 tell the consumer to stall.
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave rf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ADR_ZERO = '0;
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    logic [XLEN-1:0]  regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_nxt;
    logic             wr_ok;
    logic             iss_ok;
    logic             cnt_inc;
    logic             cnt_dec;
    logic             hit1;
    logic             hit2;
    logic             fwd1;
    logic             fwd2;

    // Address 0 is hard-wired: neither writes nor issues to it have any effect
    assign wr_ok  = rf.en && (rf.w_adr != ADR_ZERO);
    assign iss_ok = rf.iss_en && (rf.iss_adr != ADR_ZERO);

    // Forwarding matches: hitN masks busy, fwdN additionally excludes x0 for data
    assign hit1 = (BYPASS != 0) && rf.en && (rf.w_adr == rf.adr1);
    assign hit2 = (BYPASS != 0) && rf.en && (rf.w_adr == rf.adr2);
    assign fwd1 = hit1 && (rf.adr1 != ADR_ZERO);
    assign fwd2 = hit2 && (rf.adr2 != ADR_ZERO);

    assign rf.rs1      = fwd1 ? rf.w_data : regs[rf.adr1];
    assign rf.rs2      = fwd2 ? rf.w_data : regs[rf.adr2];
    assign rf.busy1    = busy[rf.adr1] & ~hit1;
    assign rf.busy2    = busy[rf.adr2] & ~hit2;
    assign rf.busy_cnt = cnt_q;

    // Next busy vector and incremental count; issue is applied last so it wins a same-address collision
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[rf.w_adr] = 1'b0;
        end
        if (iss_ok) begin
            busy_nxt[rf.iss_adr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;

        // Count moves only when a bit actually flips
        cnt_inc = iss_ok && !busy[rf.iss_adr];
        cnt_dec = wr_ok && busy[rf.w_adr] && !(iss_ok && (rf.iss_adr == rf.w_adr));

        cnt_nxt = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_nxt = cnt_q + CNT_ONE;
        end else if (!cnt_inc && cnt_dec) begin
            cnt_nxt = cnt_q - CNT_ONE;
        end
    end

    // Scoreboard state; reset has priority over any issue or write
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= '0;
            cnt_q <= '0;
        end else begin
            busy  <= busy_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    // Register storage; entry 0 is only ever written with zero by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[rf.w_adr] <= rf.w_data;
        end
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of every register.
REQ-002 SHALL have parameter DEPTH, default 32, register count; power of two, at least 2; AW = clog2(DEPTH).
REQ-003 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = no forwarding.
REQ-004 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-005 SHALL have port rst, input, 1, reset; synchronous to clk and active-high.
REQ-006 SHALL have port adr1, input, AW, read port 1 address.
REQ-007 SHALL have port adr2, input, AW, read port 2 address.
REQ-008 SHALL have port rs1, output, XLEN, read port 1 data.
REQ-009 SHALL have port rs2, output, XLEN, read port 2 data.
REQ-010 SHALL have port busy1, output, 1, register at adr1 has a write pending.
REQ-011 SHALL have port busy2, output, 1, register at adr2 has a write pending.
REQ-012 SHALL have port en, input, 1, write enable.
REQ-013 SHALL have port w_adr, input, AW, write address.
REQ-014 SHALL have port w_data, input, XLEN, write data.
REQ-015 SHALL have port iss_en, input, 1, issue strobe that marks iss_adr as a pending destination.
REQ-016 SHALL have port iss_adr, input, AW, destination address being issued.
REQ-017 SHALL have port busy_cnt, output, AW+1, count of registers currently marked busy.

Function
REQ-018 SHALL write reg[w_adr] <= w_data on the rising clk edge when en=1 and w_adr!=0; this replaces the earlier falling-edge write.
REQ-019 SHALL keep reg[0] at 0 permanently; writes to address 0 are discarded.
REQ-020 SHALL perform reads asynchronously: rsN = reg[adrN].
REQ-021 With BYPASS=1: SHALL drive rsN = w_data when en=1, w_adr=adrN and adrN!=0, giving zero-latency forwarding.
REQ-022 With BYPASS=0: SHALL return the old register contents during the write cycle; new data is visible the next cycle.
REQ-023 SHALL hold one busy bit per register; busy[0] is always 0.
REQ-024 SHALL set busy[iss_adr] on the clock edge when iss_en=1 and iss_adr!=0.
REQ-025 SHALL clear busy[w_adr] on the clock edge when en=1 and w_adr!=0.
REQ-026 When issue and write hit the same address in one cycle, SHALL let the issue win: busy remains 1 (new producer).
REQ-027 SHALL allow issue and write to different addresses in the same cycle, each taking effect independently.
REQ-028 SHALL drive busyN = busy[adrN] & ~(BYPASS & en & (w_adr==adrN)); a forwarded operand is not busy.
REQ-029 SHALL register busy_cnt as the population count of busy[]; it updates on the same edge as the busy bits.
REQ-030 SHALL have busy_cnt change by at most +1/-1 per cycle and never exceed DEPTH-1.
REQ-031 SHALL leave busy_cnt unchanged when an issue hits a register that is already busy, and when a write hits a register that is not busy.

Reset
REQ-032 When rst=1 at a clock edge, SHALL clear all registers to 0, all busy bits to 0 and busy_cnt to 0.
REQ-033 SHALL let rst override en and iss_en in the same cycle: no write or issue takes effect.
REQ-034 After reset is released, SHALL read 0 on every address and hold busy1 = busy2 = 0.
REQ-035 SHALL produce no X on any output after the first reset edge.

Verification
REQ-036 Write then read: en=1, w_adr=5, w_data=0xDEADBEEF -> the next cycle, adr1=5 gives rs1=0xDEADBEEF.
REQ-037 x0 protection: en=1, w_adr=0, w_data=0xFFFFFFFF and iss_en=1, iss_adr=0 -> rs1(adr1=0)=0, busy1=0, busy_cnt=0.
REQ-038 Bypass: BYPASS=1, en=1, w_adr=7, w_data=0x1234, adr2=7 in the same cycle -> rs2=0x1234, busy2=0; with BYPASS=0 -> rs2 = old value.
REQ-039 Scoreboard: issue 3, issue 9, then write 3 -> busy_cnt goes 1, 2, 1; busy1(adr1=9)=1; busy1(adr1=3)=0.
REQ-040 Collision: reg 4 busy, then iss_en=1, iss_adr=4 with en=1, w_adr=4 -> busy[4] stays 1 and busy_cnt is unchanged; register 4 is written.
REQ-041 Reset mid-operation: 3 registers busy and reg 6=0xAA, assert rst with en=1 -> busy_cnt=0, reg 6 reads 0, and the write is not performed.
REQ-042 Parameter sweep: repeat REQ-036 to REQ-041 with XLEN=16, DEPTH=8, checking busy_cnt width 4 and address wrap at 7.
